// File: rtl/gen_tick_multi.sv
// gen_tick_multi: NUM_CH independent tick dividers with shadowed, glitch-free divisor updates.
// Optional per-channel 16-bit event counters are built when GEN_TICK_EVCNT_EN is defined.
module gen_tick_multi #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    parameter int SRC_FREQ  = 5000,
    parameter int TICK_FREQ = 1
) (
    input  logic                 src_clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    enable,
    input  logic [NUM_CH-1:0]    mode,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_ch,
    input  logic [CNT_W-1:0]     cfg_div,
    output logic [NUM_CH-1:0]    cfg_pend,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH*16-1:0] ev_cnt
);

    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(SRC_FREQ / TICK_FREQ);
    localparam logic [CNT_W-1:0] ZERO_DIV = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_DIV  = {{(CNT_W-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             mode_q;
        logic             run_s, ev_s, wr_s, apply_s;

        // Indices at or above NUM_CH never match any channel, so such writes are dropped.
        assign wr_s    = cfg_we && (cfg_ch == 4'(i));
        assign run_s   = enable[i] && (div_q != ZERO_DIV);
        assign ev_s    = run_s && (cnt_q == (div_q - ONE_DIV));
        assign apply_s = pend_q && (!run_s || ev_s);

        // Next-state for counter, divisor pair, pending flag and tick.
        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            tick_d = tick_q;

            if (!run_s || ev_s) begin
                cnt_d = ZERO_DIV;
            end else begin
                cnt_d = cnt_q + ONE_DIV;
            end

            if (apply_s) begin
                div_d = shd_q;
            end else begin
                div_d = div_q;
            end

            // A write on an apply edge lands in the shadow and keeps the flag raised.
            if (wr_s) begin
                shd_d  = cfg_div;
                pend_d = 1'b1;
            end else if (apply_s) begin
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q;
            end

            if (!run_s || (mode[i] != mode_q)) begin
                tick_d = 1'b0;
            end else if (mode[i]) begin
                tick_d = ev_s;
            end else begin
                tick_d = tick_q ^ ev_s;
            end
        end

        // Channel state registers.
        always_ff @(posedge src_clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= ZERO_DIV;
                div_q  <= DEF_DIV;
                shd_q  <= DEF_DIV;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                mode_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                mode_q <= mode[i];
            end
        end

        assign tick[i]     = tick_q;
        assign cfg_pend[i] = pend_q;

`ifdef GEN_TICK_EVCNT_EN
        logic [15:0] ev_q, ev_d;

        // Event counter next-state: wraps naturally at 16 bits.
        always_comb begin
            ev_d = ev_q;
            if (!enable[i]) begin
                ev_d = 16'h0000;
            end else if (ev_s) begin
                ev_d = ev_q + 16'h0001;
            end else begin
                ev_d = ev_q;
            end
        end

        // Event counter register.
        always_ff @(posedge src_clk or negedge rst_n) begin
            if (!rst_n) begin
                ev_q <= 16'h0000;
            end else begin
                ev_q <= ev_d;
            end
        end

        assign ev_cnt[16*i +: 16] = ev_q;
`else
        assign ev_cnt[16*i +: 16] = 16'h0000;
`endif
    end

endmodule

// File: tb/tb_gen_tick_multi.sv
// Self-checking bench for gen_tick_multi: vector table with a scoreboard queue,
// plus directed sequences for shadow updates, mode changes and asynchronous reset.
module tb_gen_tick_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic                 src_clk = 1'b0;
    logic                 rst_n   = 1'b0;
    logic [NUM_CH-1:0]    enable  = '0;
    logic [NUM_CH-1:0]    mode    = '0;
    logic                 cfg_we  = 1'b0;
    logic [3:0]           cfg_ch  = 4'd0;
    logic [CNT_W-1:0]     cfg_div = 32'd0;
    logic [NUM_CH-1:0]    cfg_pend;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH*16-1:0] ev_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        logic [31:0] div;
        logic        md;
        int          lat;
        int          hi;
    } vec_t;

    typedef struct {
        int lat;
        int hi;
    } exp_t;

    vec_t vecs [0:7];
    exp_t sb_q [$];

    gen_tick_multi #(
        .NUM_CH   (4),
        .CNT_W    (32),
        .SRC_FREQ (5000),
        .TICK_FREQ(1)
    ) dut (
        .src_clk (src_clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .mode    (mode),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_pend(cfg_pend),
        .tick    (tick),
        .ev_cnt  (ev_cnt)
    );

    always #5 src_clk = ~src_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge src_clk);
        #1;
    endtask

    task automatic apply_reset();
        enable  = '0;
        mode    = '0;
        cfg_we  = 1'b0;
        cfg_ch  = 4'd0;
        cfg_div = 32'd0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic cfg_write(input int c, input logic [31:0] d);
        cfg_we  = 1'b1;
        cfg_ch  = 4'(c);
        cfg_div = d;
        step();
        cfg_we  = 1'b0;
    endtask

    // Steps until tick[c]==v; n = steps taken, or -1 when the bound expires.
    task automatic wait_for(input int c, input logic v, input int bound, output int n);
        n = 0;
        while ((tick[c] !== v) && (n <= bound)) begin
            step();
            n++;
        end
        if (n > bound) n = -1;
    endtask

    initial begin
        int   n;
        int   lat;
        int   hi;
        exp_t e;

        // ch, div, mode, first-rise latency (0 = never), highs in 24 samples from the rise
        vecs[0] = '{0, 32'd1, 1'b0, 1, 12};
        vecs[1] = '{1, 32'd4, 1'b1, 4, 6};
        vecs[2] = '{2, 32'd3, 1'b0, 3, 12};
        vecs[3] = '{3, 32'd5, 1'b0, 5, 14};
        vecs[4] = '{0, 32'd1, 1'b1, 1, 24};
        vecs[5] = '{2, 32'd7, 1'b1, 7, 4};
        vecs[6] = '{1, 32'd2, 1'b0, 2, 12};
        vecs[7] = '{3, 32'd0, 1'b0, 0, 0};

        apply_reset();
        chk("reset_tick", 64'(tick), 64'd0);
        chk("reset_pend", 64'(cfg_pend), 64'd0);
        chk("reset_evcnt", ev_cnt, 64'd0);

        for (int v = 0; v < 8; v++) begin
            apply_reset();
            mode[vecs[v].ch] = vecs[v].md;
            cfg_write(vecs[v].ch, vecs[v].div);
            step();
            enable[vecs[v].ch] = 1'b1;
            sb_q.push_back('{vecs[v].lat, vecs[v].hi});
            wait_for(vecs[v].ch, 1'b1, 40, n);
            lat = (n < 0) ? 0 : n;
            hi  = 0;
            for (int k = 0; k < 24; k++) begin
                if (k > 0) step();
                if (tick[vecs[v].ch] === 1'b1) hi++;
            end
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(e.lat));
            chk($sformatf("vec%0d_highs", v), 64'(hi), 64'(e.hi));
        end

        // Reset-default divisor of 5000 on channel 0, toggle mode.
        apply_reset();
        enable[0] = 1'b1;
        wait_for(0, 1'b1, 6000, n);
        chk("def_first_rise", 64'(n), 64'd5000);
        wait_for(0, 1'b0, 6000, n);
        chk("def_half_period", 64'(n), 64'd5000);

        // Write with enable low applies on the next cycle.
        apply_reset();
        cfg_write(1, 32'd4);
        chk("pend_set", 64'(cfg_pend), 64'd2);
        step();
        chk("pend_clear_disabled", 64'(cfg_pend), 64'd0);

        // Out-of-range channel index is ignored.
        apply_reset();
        cfg_write(4, 32'd7);
        chk("bad_ch_pend", 64'(cfg_pend), 64'd0);

        // Mid-period divisor change on channel 2: 10 -> 3.
        apply_reset();
        cfg_write(2, 32'd10);
        step();
        enable[2] = 1'b1;
        wait_for(2, 1'b1, 20, n);
        chk("ch2_first_rise", 64'(n), 64'd10);
        repeat (5) step();
        cfg_write(2, 32'd3);
        chk("ch2_pend_set", 64'(cfg_pend[2]), 64'd1);
        wait_for(2, 1'b0, 20, n);
        chk("ch2_old_high", 64'((n < 0) ? -1 : 6 + n), 64'd10);
        chk("ch2_pend_clear", 64'(cfg_pend[2]), 64'd0);
        wait_for(2, 1'b1, 20, n);
        chk("ch2_new_low", 64'(n), 64'd3);
        wait_for(2, 1'b0, 20, n);
        chk("ch2_new_high", 64'(n), 64'd3);

        // Idle channel with div 0, then a live write.
        apply_reset();
        cfg_write(3, 32'd0);
        step();
        enable[3] = 1'b1;
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick[3] !== 1'b0) hi++;
        end
        chk("ch3_idle", 64'(hi), 64'd0);
        cfg_write(3, 32'd2);
        wait_for(3, 1'b1, 10, n);
        chk("ch3_first_rise", 64'(n), 64'd3);
        wait_for(3, 1'b0, 10, n);
        chk("ch3_fall", 64'(n), 64'd2);
        wait_for(3, 1'b1, 10, n);
        chk("ch3_rise", 64'(n), 64'd2);

        // Back-to-back writes on a running pulse channel: last one wins.
        apply_reset();
        mode[1] = 1'b1;
        cfg_write(1, 32'd10);
        step();
        enable[1] = 1'b1;
        wait_for(1, 1'b1, 20, n);
        chk("b2b_first_pulse", 64'(n), 64'd10);
        cfg_write(1, 32'd2);
        cfg_write(1, 32'd3);
        chk("b2b_pend", 64'(cfg_pend[1]), 64'd1);
        wait_for(1, 1'b1, 20, n);
        chk("b2b_old_period", 64'(n), 64'd8);
        chk("b2b_pend_clear", 64'(cfg_pend[1]), 64'd0);
        wait_for(1, 1'b0, 20, n);
        chk("b2b_pulse_width", 64'(n), 64'd1);
        wait_for(1, 1'b1, 20, n);
        chk("b2b_new_period", 64'(n), 64'd2);

        // Mode change while running clears tick, counter continues.
        apply_reset();
        cfg_write(0, 32'd4);
        step();
        enable[0] = 1'b1;
        wait_for(0, 1'b1, 20, n);
        chk("mode_first_rise", 64'(n), 64'd4);
        mode[0] = 1'b1;
        step();
        chk("mode_change_clear", 64'(tick[0]), 64'd0);
        wait_for(0, 1'b1, 20, n);
        chk("mode_next_pulse", 64'(n), 64'd3);
        wait_for(0, 1'b0, 20, n);
        chk("mode_pulse_width", 64'(n), 64'd1);

        // Asynchronous reset in the middle of activity.
        apply_reset();
        mode[1] = 1'b1;
        cfg_write(1, 32'd1);
        step();
        enable[1] = 1'b1;
        enable[2] = 1'b1;
        repeat (3) step();
        cfg_write(2, 32'd9);
        chk("arst_pre_tick", 64'(tick[1]), 64'd1);
        chk("arst_pre_pend", 64'(cfg_pend[2]), 64'd1);
`ifdef GEN_TICK_EVCNT_EN
        chk("arst_pre_evcnt", 64'(ev_cnt[31:16]), 64'd4);
`else
        chk("arst_pre_evcnt", 64'(ev_cnt[31:16]), 64'd0);
`endif
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", 64'(tick), 64'd0);
        chk("arst_pend", 64'(cfg_pend), 64'd0);
        chk("arst_evcnt", ev_cnt, 64'd0);
        enable = '0;
        step();
        rst_n = 1'b1;
        step();

        // Event counter wrap on channel 0, div 1, pulse mode.
        apply_reset();
        mode[0] = 1'b1;
        cfg_write(0, 32'd1);
        step();
        enable[0] = 1'b1;
`ifdef GEN_TICK_EVCNT_EN
        repeat (65537) step();
        chk("evcnt_wrap", 64'(ev_cnt[15:0]), 64'd1);
`else
        repeat (20) step();
        chk("evcnt_tied", ev_cnt, 64'd0);
`endif
        chk("div1_pulse_high", 64'(tick[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_tick_multi.md
Name: gen_tick_multi

Overview:
Parametrised multi-channel successor to the single-channel tick generator. It holds NUM_CH independent divider channels, all clocked by one source clock. Each channel has a runtime-programmable divisor and a per-channel output mode: 50% toggle or single-cycle pulse. Divisor updates go through a shadow register and take effect glitch-free at a terminal count. The block sits between the board clock and the lab's slow-rate consumers (LED blinkers, debouncers, display scan).

Parameters:
NUM_CH, 4, number of independent tick channels (1..16)
CNT_W, 32, width of divisor and counter per channel
SRC_FREQ, 5000, source clock frequency in Hz
TICK_FREQ, 1, reset-default tick frequency in Hz; reset divisor DEF_DIV = SRC_FREQ/TICK_FREQ (localparam, truncated to CNT_W)

Ports:
src_clk  in  1  source clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  NUM_CH  per-channel run enable
mode  in  NUM_CH  per-channel mode: 0 = toggle (square wave), 1 = pulse (one src_clk cycle high per event)
cfg_we  in  1  divisor write strobe, single cycle
cfg_ch  in  4  target channel index for cfg_we
cfg_div  in  CNT_W  new divisor value
cfg_pend  out  NUM_CH  high while a channel's shadow divisor is written but not yet applied
tick  out  NUM_CH  per-channel tick output (registered)
ev_cnt  out  NUM_CH*16  per-channel event counters, channel i at [16*i+15:16*i] (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): every counter=0, active divisor and shadow divisor=DEF_DIV, tick=0, cfg_pend=0, ev_cnt=0.
- Per channel, enabled and active div>=1: the counter increments each cycle. When counter==div-1, the counter returns to 0 and an "event" occurs.
- Event period is exactly div cycles. The first event occurs div cycles after enable rises.
- Toggle mode: tick inverts on each event, giving period 2*div and 50% duty.
- Pulse mode: tick=1 for exactly the cycle following each event edge, otherwise 0.
- div==1: pulse mode gives tick constantly 1; toggle mode gives tick toggling every cycle.
- Active div==0: channel idle; counter held 0, tick held 0, no events.
- Enable low: counter=0, tick=0 (synchronous). Any pending shadow is applied immediately and cfg_pend clears.
- Mode change while enabled: tick cleared to 0 on the cycle mode differs from its registered copy; the counter is unaffected.
- Config write: with cfg_we=1 and cfg_ch<NUM_CH, the shadow takes cfg_div and cfg_pend[ch]=1 the next cycle. Writes with cfg_ch>=NUM_CH are ignored.
- Shadow apply: on an event with cfg_pend=1, the active divisor takes the shadow and cfg_pend clears. The next period uses the new divisor.
- Shadow apply when active div==0: the shadow is applied on the next cycle.
- Write in the same cycle as an event: the event applies the shadow registered before that edge. The new write lands in the shadow and cfg_pend remains/becomes 1.
- Back-to-back writes before apply: last write wins.
- Counter arithmetic is modulo 2^CNT_W. No overflow is possible, since the counter never exceeds div-1.
- Channels are fully independent. No cross-channel phase alignment is implied beyond a common reset and enable timing.

Optional Feature:
Macro GEN_TICK_EVCNT_EN.
- Defined: per-channel 16-bit ev_cnt increments on every event and wraps 0xFFFF->0x0000. It clears to 0 on reset or while the channel's enable is low.
- Undefined: no counter logic is built and ev_cnt is tied to all-zeros. The port list is unchanged.

Test Plan:
- Reset with SRC_FREQ=5000, TICK_FREQ=1: after rst_n release, enable[0]=1, mode=0 -> tick[0] first rises 5000 cycles later and toggles every 5000 cycles.
- Write cfg_ch=1, cfg_div=4; enable[1]=1, mode[1]=1 -> tick[1] high one cycle every 4 cycles, and cfg_pend[1] falls at the first event.
- Channel 2 running div=10 in toggle mode; write cfg_div=3 at counter=5 -> the current period completes at 10 cycles, subsequent half-periods are 3 cycles, and tick shows no glitch.
- cfg_div=0 on channel 3 with enable low, then enable high -> tick[3] stays 0. Then write div=2 -> tick toggles every 2 cycles starting 1+2 cycles after the write.
- Write with cfg_ch=NUM_CH (4) -> no shadow or cfg_pend change on any channel.
- With GEN_TICK_EVCNT_EN, channel 0 div=1 pulse mode for 65537 cycles -> ev_cnt[15:0] wraps to 1. Asserting rst_n=0 mid-run clears tick, cfg_pend and ev_cnt immediately, without waiting for a clock edge.
